sequence_serializer_piso: RTL and testbench



---
 rtl/piso_pkg.sv | 23 ++
 rtl/piso_bit_counter.sv | 55 +++++
 rtl/sequence_serializer_piso.sv | 186 ++++++++++++++++++
 tb/tb_sequence_serializer_piso.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// ---------------------------------------------------------------------------
// piso_pkg
//
// Shared definitions for the parallel-in/serial-out serializer that feeds the
// serial input of the Moore sequence detector.
//
// Contents:
//   piso_state_t     FSM state encoding (IDLE, SHIFT, PARITY). PARITY is only
//                    entered when the design is built with PISO_PARITY_EN.
//   PISO_IDLE_LEVEL  Level driven on the serial line when no frame bit is
//                    valid. It is kept low so the detector never sees ones.
// ---------------------------------------------------------------------------
package piso_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SHIFT  = 2'b01,
      PARITY = 2'b10
   } piso_state_t;

   localparam logic PISO_IDLE_LEVEL = 1'b0;

endpackage : piso_pkg

// File: rtl/piso_bit_counter.sv
// ---------------------------------------------------------------------------
// piso_bit_counter
//
// Bit index counter for the serializer. It counts the data bits of the
// current frame and runs from 0 to WIDTH-1. It never exceeds WIDTH-1,
// because the FSM stops enabling it on the last bit.
//
// Configuration macro: PISO_PARITY_EN. When the macro is undefined, the
// serializer needs a one-bit lookahead to register frame_done onto the last
// data bit, so the extra pre_last flag is provided. With parity enabled,
// frame_done lands on the parity cycle instead and the flag is not built.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset (counter -> 0)
//   clr       in   synchronous clear to 0 (has priority over en)
//   en        in   increment by one
//   last      out  counter == WIDTH-1 (final data bit is on the line)
//   pre_last  out  counter == WIDTH-2 (only without PISO_PARITY_EN)
// ---------------------------------------------------------------------------
module piso_bit_counter #(
   parameter int WIDTH = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic last
`ifndef PISO_PARITY_EN
   ,
   output logic pre_last
`endif
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign last = (cnt == CNT_W'(WIDTH - 1));

`ifndef PISO_PARITY_EN
   assign pre_last = (cnt == CNT_W'(WIDTH - 2));
`endif

endmodule : piso_bit_counter

// File: rtl/sequence_serializer_piso.sv
// ---------------------------------------------------------------------------
// sequence_serializer_piso
//
// Parallel-in/serial-out stage in front of the Moore sequence detector.
// WIDTH-bit words are accepted over a valid/ready handshake and shifted out
// one bit per clock. Consecutive frames follow each other with no gap cycles.
// While idle, the serial line sits at PISO_IDLE_LEVEL (0).
//
// Configuration macro: PISO_PARITY_EN
//   undefined : frames are exactly WIDTH bits, with no parity logic.
//   defined   : one trailing odd-parity bit (~^word) is appended to every
//               frame. The frame is then WIDTH+1 bits, and frame_done pulses
//               on the parity bit.
//
// Parameters:
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 is sent first, 0: bit 0 is sent first
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset
//   din         in   parallel word, sampled only on accept
//   din_valid   in   din holds a word to send
//   din_ready   out  word is accepted this cycle if din_valid (combinational)
//   out         out  serial bit to the detector input, 0 when not valid
//   out_valid   out  out carries a frame bit this cycle
//   busy        out  a frame is in progress
//   frame_done  out  one-cycle pulse on the final bit of a frame
//
// Timing: a word accepted at edge k shows bit i on out after edge k+i.
// All four serial-side outputs are registered.
// ---------------------------------------------------------------------------
module sequence_serializer_piso
   import piso_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             out,
   output logic             out_valid,
   output logic             busy,
   output logic             frame_done
);

   piso_state_t      state;
   logic [WIDTH-1:0] sreg;
   logic             accept;
   logic             last;
   logic             cnt_clr;
   logic             cnt_en;
`ifdef PISO_PARITY_EN
   logic             par_bit;
`else
   logic             pre_last;
`endif

   // Bit that goes on the line first for a given register image.
   function automatic logic first_bit(input logic [WIDTH-1:0] w);
      return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
   endfunction

   // Shift that moves the next bit into the position first_bit() reads.
   function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
      return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
   endfunction

`ifdef PISO_PARITY_EN
   // Odd parity: data bits plus parity bit always contain an odd count of ones.
   function automatic logic odd_parity(input logic [WIDTH-1:0] w);
      return ~(^w);
   endfunction
`endif

   // Ready in IDLE and on the final bit of a frame. This lets the next word
   // load on the same edge that retires the current frame, so no gap cycle
   // appears on the line.
   always_comb begin
      din_ready = 1'b0;
`ifdef PISO_PARITY_EN
      din_ready = (state == IDLE) || (state == PARITY);
`else
      din_ready = (state == IDLE) || ((state == SHIFT) && last);
`endif
   end

   assign accept = din_valid && din_ready;

   // The counter is held at 0 outside SHIFT, so every frame starts from a
   // clean index no matter how the previous one ended.
   assign cnt_clr = accept || (state != SHIFT);
   assign cnt_en  = (state == SHIFT) && !last;

   piso_bit_counter #(
      .WIDTH    (WIDTH)
   ) u_bit_counter (
      .clk      (clk),
      .rst      (rst),
      .clr      (cnt_clr),
      .en       (cnt_en),
      .last     (last)
`ifndef PISO_PARITY_EN
      ,
      .pre_last (pre_last)
`endif
   );

   // Serializer FSM and shift register.
   // An accept can only occur where a new frame is allowed to start (IDLE or
   // the final bit of a frame), so it always means "load and start bit 0".
   // The register keeps the word already shifted by one position, so that
   // first_bit(sreg) is always the next bit to present.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         sreg       <= '0;
         out        <= PISO_IDLE_LEVEL;
         out_valid  <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
`ifdef PISO_PARITY_EN
         par_bit    <= 1'b0;
`endif
      end else begin
         frame_done <= 1'b0;
         if (accept) begin
            state     <= SHIFT;
            out       <= first_bit(din);
            sreg      <= shift_word(din);
            out_valid <= 1'b1;
            busy      <= 1'b1;
`ifdef PISO_PARITY_EN
            par_bit   <= odd_parity(din);
`endif
         end else begin
            case (state)
               IDLE: begin
                  out       <= PISO_IDLE_LEVEL;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end
               SHIFT: begin
                  if (!last) begin
                     out  <= first_bit(sreg);
                     sreg <= shift_word(sreg);
`ifndef PISO_PARITY_EN
                     // The bit being loaded now is the frame's final bit.
                     frame_done <= pre_last;
`endif
                  end else begin
`ifdef PISO_PARITY_EN
                     state      <= PARITY;
                     out        <= par_bit;
                     frame_done <= 1'b1;
`else
                     state      <= IDLE;
                     out        <= PISO_IDLE_LEVEL;
                     out_valid  <= 1'b0;
                     busy       <= 1'b0;
`endif
                  end
               end
`ifdef PISO_PARITY_EN
               PARITY: begin
                  state     <= IDLE;
                  out       <= PISO_IDLE_LEVEL;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end
`endif
               default: begin
                  state     <= IDLE;
                  out       <= PISO_IDLE_LEVEL;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule : sequence_serializer_piso

// File: tb/tb_sequence_serializer_piso.sv
// ---------------------------------------------------------------------------
// tb_sequence_serializer_piso
//
// Two serializers (MSB-first and LSB-first) share the same stimulus. A
// frame-level model keeps, per instance, the queue of bits still to appear
// on the line. The model expects the following:
//   - out is the queue head;
//   - valid/busy are high whenever the queue is non-empty;
//   - frame_done is high when only the head is left;
//   - ready is high when at most the head is left.
// On each clock edge, the model pops the head and appends a full frame when
// a word is accepted.
// Directed sequences pin the model with hand-computed bit streams.
// ---------------------------------------------------------------------------
module tb_sequence_serializer_piso;

   localparam int W = 8;
`ifdef PISO_PARITY_EN
   localparam int FL = W + 1;
   localparam logic [31:0] E_B0_MSB = 32'h160;   // 10110000 + parity 0
   localparam logic [31:0] E_0D_MSB = 32'h01A;   // 00001101 + parity 0
   localparam logic [31:0] E_0D_LSB = 32'h160;   // 10110000 + parity 0
   localparam logic [31:0] E_03_MSB = 32'h007;   // 00000011 + parity 1
   localparam logic [31:0] E_0F_MSB = 32'h01F;   // 00001111 + parity 1
   localparam logic [31:0] E_0F_LSB = 32'h1E1;   // 11110000 + parity 1
   localparam logic [31:0] E_B2B    = 32'h29679; // A5,1,3C,1
`else
   localparam int FL = W;
   localparam logic [31:0] E_B0_MSB = 32'h0B0;
   localparam logic [31:0] E_0D_MSB = 32'h00D;
   localparam logic [31:0] E_0D_LSB = 32'h0B0;
   localparam logic [31:0] E_03_MSB = 32'h003;
   localparam logic [31:0] E_0F_MSB = 32'h00F;
   localparam logic [31:0] E_0F_LSB = 32'h0F0;
   localparam logic [31:0] E_B2B    = 32'hA53C;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [W-1:0] din = '0;
   logic         din_valid = 1'b0;
   logic         m_rdy, m_out, m_ov, m_busy, m_fd;
   logic         l_rdy, l_out, l_ov, l_busy, l_fd;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;
   bit q_m[$];
   bit q_l[$];
   bit acc_m;

   sequence_serializer_piso #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
      .din_ready(m_rdy), .out(m_out), .out_valid(m_ov), .busy(m_busy),
      .frame_done(m_fd));

   sequence_serializer_piso #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
      .din_ready(l_rdy), .out(l_out), .out_valid(l_ov), .busy(l_busy),
      .frame_done(l_fd));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic push_frame(input logic [W-1:0] w);
      for (int i = W - 1; i >= 0; i--) q_m.push_back(w[i]);
      for (int i = 0; i < W; i++) q_l.push_back(w[i]);
`ifdef PISO_PARITY_EN
      q_m.push_back(~(^w));
      q_l.push_back(~(^w));
`endif
   endtask

   // Reference model: bits still owed on the line for each instance.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q_m.delete();
         q_l.delete();
      end else begin
         acc_m = din_valid && (q_m.size() <= 1);
         if (q_m.size() > 0) void'(q_m.pop_front());
         if (q_l.size() > 0) void'(q_l.pop_front());
         if (acc_m) push_frame(din);
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("msb_out",   m_out,  (q_m.size() > 0) ? q_m[0] : 1'b0);
         chk("msb_valid", m_ov,   q_m.size() > 0);
         chk("msb_busy",  m_busy, q_m.size() > 0);
         chk("msb_done",  m_fd,   q_m.size() == 1);
         chk("msb_ready", m_rdy,  q_m.size() <= 1);
         chk("lsb_out",   l_out,  (q_l.size() > 0) ? q_l[0] : 1'b0);
         chk("lsb_valid", l_ov,   q_l.size() > 0);
         chk("lsb_busy",  l_busy, q_l.size() > 0);
         chk("lsb_done",  l_fd,   q_l.size() == 1);
         chk("lsb_ready", l_rdy,  q_l.size() <= 1);
      end
   end

   // Send one word from idle and record FL bits plus two trailing cycles.
   task automatic send_capture(input logic [W-1:0] w, output logic [31:0] sm,
                               output logic [31:0] sl, output int nv,
                               output logic [31:0] fdm);
      sm = '0; sl = '0; nv = 0; fdm = '0;
      @(negedge clk); din = w; din_valid = 1'b1;
      @(negedge clk); din_valid = 1'b0; din = W'($urandom);
      for (int i = 0; i < FL + 2; i++) begin
         if (i < FL) begin
            sm = {sm[30:0], m_out};
            sl = {sl[30:0], l_out};
         end
         if (m_ov) nv++;
         if (m_fd) fdm[i] = 1'b1;
         @(negedge clk);
      end
   endtask

   logic [31:0] sm, sl, fdm, b2b, rmask;
   int          nv, bad, nfd, pct;

   initial begin
      #1 rst = 1'b1;
      @(negedge clk);
      // Reset state
      chk("rst_out",   m_out,  1'b0);
      chk("rst_valid", m_ov,   1'b0);
      chk("rst_busy",  m_busy, 1'b0);
      chk("rst_done",  m_fd,   1'b0);
      chk("rst_ready", m_rdy,  1'b1);
      @(negedge clk); rst = 1'b0; chk_en = 1'b1;

      // Idle with din_valid low
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         din = W'($urandom);
         if (m_out || m_ov || m_busy || !m_rdy || l_out || l_ov) bad++;
      end
      chk("idle_quiet_cycles", bad, 0);

      // Single words
      send_capture(8'hB0, sm, sl, nv, fdm);
      chk("b0_msb_stream", sm, E_B0_MSB);
      chk("b0_valid_cycles", nv, FL);
      chk("b0_done_pos", fdm, 32'h1 << (FL - 1));
      send_capture(8'h0D, sm, sl, nv, fdm);
      chk("0d_lsb_stream", sl, E_0D_LSB);
      chk("0d_msb_stream", sm, E_0D_MSB);
      send_capture(8'h03, sm, sl, nv, fdm);
      chk("03_msb_stream", sm, E_03_MSB);
      chk("03_done_pos", fdm, 32'h1 << (FL - 1));

      // Back-to-back frames with din_valid held
      b2b = '0; rmask = '0; nfd = 0; bad = 0;
      for (int c = 0; c <= 2 * FL + 1; c++) begin
         @(negedge clk);
         if (c < 2 * FL && m_rdy) rmask[c] = 1'b1;
         if (c >= 1 && c <= 2 * FL) begin
            b2b = {b2b[30:0], m_out};
            if (!m_ov) bad++;
         end
         if (m_fd) nfd++;
         din = (c == 0) ? 8'hA5 : 8'h3C;
         din_valid = (c <= FL);
      end
      din_valid = 1'b0;
      chk("b2b_stream", b2b, E_B2B);
      chk("b2b_valid_gaps", bad, 0);
      chk("b2b_ready_mask", rmask, (32'h1 << FL) | 32'h1);
      chk("b2b_done_count", nfd, 2);

      // Reset in the middle of a frame
      @(negedge clk); din = 8'hFF; din_valid = 1'b1;
      @(negedge clk); din_valid = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_out",   m_out, 1'b0);
      chk("midrst_valid", m_ov,  1'b0);
      chk("midrst_busy",  m_busy, 1'b0);
      chk("midrst_lsb",   {l_out, l_ov}, 2'b00);
      @(negedge clk); rst = 1'b0;
      send_capture(8'h0F, sm, sl, nv, fdm);
      chk("after_rst_msb", sm, E_0F_MSB);
      chk("after_rst_lsb", sl, E_0F_LSB);
      chk("after_rst_valid", nv, FL);

      // Randomized traffic with varying load and occasional async resets
      for (int n = 0; n < 3000; n++) begin
         if (n % 150 == 0) pct = (n % 450 == 0) ? 100 : ((n % 300 == 0) ? 20 : 70);
         @(negedge clk);
         din = W'($urandom);
         din_valid = ($urandom_range(0, 99) < pct);
         if ($urandom_range(0, 249) == 0) begin
            #2 rst = 1'b1;
            @(negedge clk); rst = 1'b0;
         end
      end
      @(negedge clk); din_valid = 1'b0;
      repeat (FL + 2) @(negedge clk);
      chk_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_sequence_serializer_piso
